// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the multi-way set RAM.
package sargantana_icache_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int unsigned DEFAULT_N_WAYS     = 4;
    localparam int unsigned DEFAULT_WAY_WIDTH  = 256;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
    localparam int unsigned DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/sargantana_set_ram_way.sv
// One way of the set RAM: synchronous write with enable, registered read port.
module sargantana_set_ram_way
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned WAY_WIDTH  = DEFAULT_WAY_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WAY_WIDTH-1:0]  wdata_i,
    output logic [WAY_WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WAY_WIDTH-1:0] mem_q [DEPTH];
    logic [WAY_WIDTH-1:0] rdata_q;

    // NOTE: the array has no reset so it can map onto a RAM macro; the INIT sweep clears it instead.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sargantana_set_ram_multiway.sv
// N-way set RAM with a clearing sweep after reset/flush and a 1- or 2-cycle read pipeline.
module sargantana_set_ram_multiway
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAYS       = DEFAULT_N_WAYS,
    parameter int unsigned WAY_WIDTH    = DEFAULT_WAY_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [N_WAYS-1:0]           way_en_i,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic [WAY_WIDTH-1:0]        data_i,
    input  logic                        flush_i,
    output logic                        ready_o,
    output logic [N_WAYS*WAY_WIDTH-1:0] data_o,
    output logic                        valid_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    ram_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       sweep_q, sweep_d;
    logic                        accept, rd_accept, wr_accept, sweeping;
    logic [ADDR_WIDTH-1:0]       ram_addr;
    logic [WAY_WIDTH-1:0]        ram_wdata;
    logic [N_WAYS*WAY_WIDTH-1:0] way_rdata;
    logic                        valid1_q;

    assign ready_o   = (state_q == RUN) && !rst_i;
    assign accept    = req_i && ready_o;
    assign rd_accept = accept && !we_i;
    assign wr_accept = accept && we_i;
    assign sweeping  = (state_q == INIT) && !rst_i;

    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            INIT: begin
                if (sweep_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign ram_addr  = sweeping ? sweep_q : addr_i;
    assign ram_wdata = sweeping ? '0 : data_i;

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        sargantana_set_ram_way #(
            .WAY_WIDTH  (WAY_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_way (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (sweeping || (wr_accept && way_en_i[w])),
            .re_i    (rd_accept),
            .addr_i  (ram_addr),
            .wdata_i (ram_wdata),
            .rdata_o (way_rdata[w*WAY_WIDTH +: WAY_WIDTH])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= rd_accept;
        end
    end

    // The way read registers are the first stage; latency 2 adds one holding stage here.
    if (READ_LATENCY == 2) begin : g_lat2
        logic                        valid2_q;
        logic [N_WAYS*WAY_WIDTH-1:0] data2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                valid2_q <= 1'b0;
                data2_q  <= '0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    data2_q <= way_rdata;
                end
            end
        end

        assign valid_o = valid2_q;
        assign data_o  = data2_q;
    end else begin : g_lat1
        assign valid_o = valid1_q;
        assign data_o  = way_rdata;
    end

endmodule

// File: tb/tb_sargantana_set_ram_multiway.sv
// Scoreboard bench: one DUT per read latency, shared stimulus, model of the RAM contents and sweep time.
module tb_sargantana_set_ram_multiway;

    localparam int NW    = 4;
    localparam int WW    = 256;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int DW    = NW * WW;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
    logic [NW-1:0] way_en_i = '0;
    logic [AW-1:0] addr_i = '0;
    logic [WW-1:0] data_i = '0;
    logic          ready1, ready2, valid1, valid2;
    logic [DW-1:0] dout1, dout2;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    int            init_left = DEPTH;
    logic [WW-1:0] mmem [DEPTH][NW];
    logic [DW-1:0] last1 = '0, last2 = '0;
    exp_t          q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sargantana_set_ram_multiway #(.N_WAYS(NW), .WAY_WIDTH(WW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .way_en_i(way_en_i),
        .addr_i(addr_i), .data_i(data_i), .flush_i(flush_i),
        .ready_o(ready1), .data_o(dout1), .valid_o(valid1));

    sargantana_set_ram_multiway #(.N_WAYS(NW), .WAY_WIDTH(WW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .way_en_i(way_en_i),
        .addr_i(addr_i), .data_i(data_i), .flush_i(flush_i),
        .ready_o(ready2), .data_o(dout2), .valid_o(valid2));

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        for (int w = 0; w < NW; w++) begin
            check($sformatf("%s_way%0d", name, w), act[w*WW +: WW], exp[w*WW +: WW]);
        end
    endtask

    function automatic logic [WW-1:0] r256();
        logic [WW-1:0] v;
        for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic void wipe();
        for (int a = 0; a < DEPTH; a++)
            for (int w = 0; w < NW; w++) mmem[a][w] = '0;
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        logic [DW-1:0] v;
        for (int w = 0; w < NW; w++) v[w*WW +: WW] = mmem[a][w];
        return v;
    endfunction

    // Drive one cycle of inputs, step past the edge, then apply the same cycle to the model.
    task automatic issue(input bit rst, input bit req, input bit we, input logic [NW-1:0] en,
                         input logic [AW-1:0] addr, input logic [WW-1:0] data, input bit flush);
        bit   mready;
        exp_t e;
        rst_i = rst; req_i = req; we_i = we; way_en_i = en;
        addr_i = addr; data_i = data; flush_i = flush;
        mready = (init_left == 0) && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            init_left = DEPTH;
            wipe();
            for (int i = q1.size() - 1; i >= 0; i--) if (q1[i].due >= cyc) q1.delete(i);
            for (int i = q2.size() - 1; i >= 0; i--) if (q2[i].due >= cyc) q2.delete(i);
            last1 = '0;
            last2 = '0;
        end else if (mready) begin
            if (req && we) begin
                for (int w = 0; w < NW; w++) if (en[w]) mmem[addr][w] = data;
            end else if (req) begin
                e.data = model_read(int'(addr));
                e.due  = cyc;
                q1.push_back(e);
                e.due  = cyc + 1;
                q2.push_back(e);
            end
            if (flush) begin
                wipe();
                init_left = DEPTH;
            end
        end else if (init_left > 0) begin
            init_left--;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(0, 0, 0, '0, '0, '0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        issue(0, 1, 0, '0, a, '0, 0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NW-1:0] en, input logic [WW-1:0] d);
        issue(0, 1, 1, en, a, d, 0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready1 !== 1'b1 && n < 300) begin
            idle(1);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout waited=%0d cycles without ready_o", n);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t qfront(input int k);
        return (k == 0) ? q1[0] : q2[0];
    endfunction

    function automatic void qpop(input int k);
        if (k == 0) void'(q1.pop_front());
        else        void'(q2.pop_front());
    endfunction

    task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
        exp_t e;
        while (qsize(k) > 0 && qfront(k).due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_valid_lat%0d due=%0d now=%0d", k + 1, qfront(k).due, cyc);
            qpop(k);
        end
        if (v === 1'b1) begin
            if (qsize(k) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid_lat%0d at cycle %0d (no read outstanding)", k + 1, cyc);
            end else begin
                e = qfront(k);
                qpop(k);
                check($sformatf("latency_lat%0d", k + 1), WW'(cyc), WW'(e.due));
                check_data($sformatf("rdata_lat%0d", k + 1), d, e.data);
                if (k == 0) last1 = e.data;
                else        last2 = e.data;
            end
        end else begin
            check($sformatf("valid_lat%0d", k + 1), WW'(v), '0);
            check_data($sformatf("hold_lat%0d", k + 1), d, (k == 0) ? last1 : last2);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_lat1", WW'(ready1), WW'((init_left == 0) && !rst_i));
            check("ready_lat2", WW'(ready2), WW'((init_left == 0) && !rst_i));
            mon(0, valid1, dout1);
            mon(1, valid2, dout2);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        wipe();
        issue(1, 0, 0, '0, '0, '0, 0);
        mon_en = 1'b1;
        issue(1, 0, 0, '0, '0, '0, 0);

        // Release reset: exactly DEPTH cycles not ready, swept memory reads zero.
        wait_ready(n);
        check("init_cycles_after_reset", WW'(n), WW'(DEPTH));
        rd(6'd63);
        idle(2);

        // Partial way enable.
        wr(6'd5, 4'b0101, {32{8'hA5}});
        rd(6'd5);
        idle(2);

        // Write right after a read to the same set must not disturb it; read after write sees new data.
        wr(6'd7, 4'b1111, {32{8'h11}});
        rd(6'd7);
        wr(6'd7, 4'b1111, {32{8'h22}});
        rd(6'd7);
        wr(6'd8, 4'b0000, {32{8'h77}});
        rd(6'd8);
        idle(2);

        // Read issued together with flush still completes; then a full sweep clears the set.
        wr(6'd9, 4'b1111, {32{8'h33}});
        issue(0, 1, 0, '0, 6'd9, '0, 1);
        wait_ready(n);
        check("init_cycles_after_flush", WW'(n), WW'(DEPTH));
        rd(6'd9);
        idle(2);

        // Read in flight when reset hits: the 2-cycle pipeline drops it.
        rd(6'd9);
        issue(1, 0, 0, '0, '0, '0, 0);
        issue(0, 0, 0, '0, '0, '0, 0);
        wait_ready(n);

        // Reset at sweep count 30; flush during INIT is ignored; sweep restarts on release.
        wr(6'd4, 4'b1111, {32{8'h44}});
        issue(0, 0, 0, '0, '0, '0, 1);
        idle(10);
        issue(0, 0, 0, '0, '0, '0, 1);
        idle(19);
        issue(1, 0, 0, '0, '0, '0, 0);
        wait_ready(n);
        check("init_cycles_after_mid_sweep_reset", WW'(n), WW'(DEPTH));

        // Request during INIT is dropped.
        issue(0, 0, 0, '0, '0, '0, 1);
        wr(6'd2, 4'b1111, {32{8'hFF}});
        rd(6'd2);
        wait_ready(n);
        rd(6'd2);
        rd(6'd4);
        idle(2);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            bit            r, q, we, fl;
            logic [AW-1:0] a;
            r  = ($urandom_range(0, 149) == 0);
            fl = ($urandom_range(0, 39) == 0);
            q  = ($urandom_range(0, 3) != 0);
            we = $urandom_range(0, 1);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            issue(r, q, we, NW'($urandom_range(0, 15)), a, r256(), fl);
        end

        idle(4);
        check("drain_lat1", WW'(q1.size()), '0);
        check("drain_lat2", WW'(q2.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sargantana_set_ram_multiway.md
SARGANTANA_SET_RAM_MULTIWAY -- requirements
Module: sargantana_set_ram_multiway

Interface
REQ-001 The block SHALL have parameter N_WAYS, default 4: number of ways stored side by side.
REQ-002 The block SHALL have parameter WAY_WIDTH, default 256: bits per way entry.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 6: set index width, DEPTH = 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 cycles from read accept to valid_o.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset, with these ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset.
REQ-006 The block SHALL have request ports:
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read.
- way_en_i  in  N_WAYS  per-way write enable; ignored on reads.
- addr_i  in  ADDR_WIDTH  set index.
- data_i  in  WAY_WIDTH  write data, the same for every enabled way.
REQ-007 The block SHALL have control ports:
- flush_i  in  1  start a clearing sweep.
- ready_o  out  1  block accepts requests.
REQ-008 The block SHALL have response ports:
- data_o  out  N_WAYS*WAY_WIDTH  read data; way i at bits [i*WAY_WIDTH +: WAY_WIDTH].
- valid_o  out  1  one-cycle pulse when data_o carries new read data.

Function
REQ-009 The block SHALL have FSM states INIT and RUN; ready_o = 1 only in RUN.
REQ-010 In INIT, the block SHALL write zero to all ways at a sweep counter address, one address per cycle, starting at 0.
REQ-011 The block SHALL go from INIT to RUN in the cycle after the write to DEPTH-1; the sweep counter SHALL NOT wrap or overflow.
REQ-012 A request SHALL be accepted only when req_i & ready_o; requests made during INIT SHALL be dropped silently, with no state change and no valid_o.
REQ-013 On an accepted write, the block SHALL load data_i into memory[w][addr_i] for each w with way_en_i[w]=1; data_o and valid_o SHALL be unchanged.
REQ-014 A write with way_en_i = 0 SHALL be accepted and have no effect.
REQ-015 On an accepted read, the block SHALL sample all N_WAYS entries at addr_i at the accept edge, present them on data_o, and pulse valid_o exactly READ_LATENCY cycles after accept.
REQ-016 data_o SHALL hold its last read value until the next read completes.
REQ-017 Read throughput SHALL be one per cycle at both latencies; back-to-back reads SHALL return in issue order.
REQ-018 A write in the cycle after a read to the same address SHALL NOT affect that read's data (READ_LATENCY=2 included).
REQ-019 A read in the cycle after a write to the same address SHALL return the new data.
REQ-020 flush_i in RUN SHALL move the FSM to INIT on the next edge, and the sweep SHALL restart at address 0.
REQ-021 A request accepted in the same cycle as flush_i SHALL complete normally; a read completes before the sweep clears that set.
REQ-022 flush_i during INIT SHALL be ignored; the current sweep continues and is not restarted.
REQ-023 Reads already in the pipeline when a flush starts SHALL still deliver valid_o and data.

Reset
REQ-024 While rst_i = 1, the block SHALL force data_o = 0, valid_o = 0, ready_o = 0, sweep counter = 0, and state = INIT.
REQ-025 rst_i SHALL also flush the read pipeline, so no valid_o appears for reads issued before reset.
REQ-026 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0 after rst_i falls; memory contents need not be reset directly.

Structure
REQ-027 The shared package sargantana_icache_pkg SHALL hold the FSM state typedef (INIT, RUN) and the default way, width and depth constants.
REQ-028 Per-way storage SHALL be one sub-module, sargantana_set_ram_way, instantiated N_WAYS times: synchronous write with enable, registered read.
REQ-029 The parent block SHALL own the FSM, the sweep counter, the read-latency pipeline and the data_o packing.

Verification
REQ-030 The bench SHALL cover these directed scenarios, using defaults unless noted (N_WAYS=4, WAY_WIDTH=256, ADDR_WIDTH=6, DEPTH=64):
- Release rst_i, no flush -> ready_o=0 for exactly 64 cycles, then 1. A read at addr 63 returns data_o = 0 with valid_o after 1 cycle.
- Write addr 5, way_en_i=4'b0101, data_i=0xA5..A5; then read addr 5 -> ways 0 and 2 = 0xA5..A5, ways 1 and 3 = 0. With READ_LATENCY=2, valid_o arrives 2 cycles after accept.
- READ_LATENCY=2: read addr 7 (holding 0x11..), then write addr 7 = 0x22.. on the next cycle -> returned data is 0x11...
- Issue flush_i together with a read of addr 9 (holding 0x33..) -> valid_o with 0x33..; ready_o low for 64 cycles; a later read of addr 9 returns 0.
- Assert rst_i at sweep count 30 with a read in flight -> no valid_o; after release, ready_o rises exactly 64 cycles later.
- Issue req_i during INIT as write addr 2 = 0xFF.., then read addr 2 in RUN -> returns 0 and no early valid_o.
